// File: rtl/v_issue_ctrl.sv
// v_issue_ctrl: vector instruction issue sequencer (instruction FIFO + single in-flight issue FSM).
// Optional WAIT watchdog is compiled in when V_ISSUE_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | nothing in flight; pop the FIFO head into the issued registers when present
// ISSUE | one-cycle start pulse on the unit selected by unit_sel
// WAIT  | wait for the selected unit's done (other units' done ignored)
// WB    | one-cycle writeback enable selected by wb_dest
module v_issue_ctrl #(
    parameter int QDEPTH         = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic [1:0]  unit_sel,
    input  logic [1:0]  wb_dest,
    output logic        start_vlanes,
    output logic        start_vred,
    output logic        start_vsldu,
    input  logic        done_vlanes,
    input  logic        done_vred,
    input  logic        done_vsldu,
    output logic [31:0] issued_instr,
    output logic        v_reg_wr_en,
    output logic        x_reg_wr_en,
    output logic        vconfig_wr_en,
    output logic        busy,
    output logic        timeout_err
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 36;

    generate
        if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 ||
            TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_param
            $error("v_issue_ctrl: QDEPTH must be a power of two >= 2, TIMEOUT_CYCLES in 1..256");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [EW-1:0] fifo_mem [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    logic [31:0]   issued_q;
    logic [1:0]    unit_q;
    logic [1:0]    wb_q;
    logic          done_sel;
    logic          tmo_hit;

    // Ready comes from the registered count only, so a same-cycle pop never raises it.
    assign fifo_full   = (count == CW'(QDEPTH));
    assign fifo_empty  = (count == '0);
    assign instr_ready = !rst && !fifo_full;
    assign push        = instr_valid && instr_ready;
    assign pop         = (state == IDLE) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {instr, unit_sel, wb_dest};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_q <= '0;
            unit_q   <= '0;
            wb_q     <= '0;
        end else if (pop) begin
            {issued_q, unit_q, wb_q} <= fifo_mem[rd_ptr];
        end
    end

    always_comb begin
        done_sel = 1'b0;
        case (unit_q)
            2'd0:    done_sel = done_vlanes;
            2'd1:    done_sel = done_vred;
            2'd2:    done_sel = done_vsldu;
            default: done_sel = 1'b0;
        endcase
    end

`ifdef V_ISSUE_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;
    logic       timeout_q;

    // A done arriving on the terminal cycle takes priority over the abort.
    assign tmo_hit = (state == WAIT) && !done_sel && (wait_cnt == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end
            if (tmo_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        start_vlanes  = 1'b0;
        start_vred    = 1'b0;
        start_vsldu   = 1'b0;
        v_reg_wr_en   = 1'b0;
        x_reg_wr_en   = 1'b0;
        vconfig_wr_en = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                case (unit_q)
                    2'd0:    start_vlanes = 1'b1;
                    2'd1:    start_vred   = 1'b1;
                    2'd2:    start_vsldu  = 1'b1;
                    default: ;
                endcase
                state_nxt = (unit_q == 2'd3) ? WB : WAIT;
            end
            WAIT: begin
                if (done_sel) begin
                    state_nxt = WB;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            WB: begin
                case (wb_q)
                    2'd0:    v_reg_wr_en   = 1'b1;
                    2'd1:    x_reg_wr_en   = 1'b1;
                    2'd3:    vconfig_wr_en = 1'b1;
                    default: ;
                endcase
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign issued_instr = issued_q;
    assign busy         = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_v_issue_ctrl.sv
// Directed self-checking bench for v_issue_ctrl; cycle 0 of each scenario is the accept cycle.
// Define V_ISSUE_TIMEOUT_EN to also exercise the WAIT watchdog (TIMEOUT_CYCLES = 8).
module tb_v_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [1:0]  unit_sel;
    logic [1:0]  wb_dest;
    logic        start_vlanes, start_vred, start_vsldu;
    logic        done_vlanes, done_vred, done_vsldu;
    logic [31:0] issued_instr;
    logic        v_reg_wr_en, x_reg_wr_en, vconfig_wr_en;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    v_issue_ctrl #(.QDEPTH(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .unit_sel(unit_sel), .wb_dest(wb_dest),
        .start_vlanes(start_vlanes), .start_vred(start_vred), .start_vsldu(start_vsldu),
        .done_vlanes(done_vlanes), .done_vred(done_vred), .done_vsldu(done_vsldu),
        .issued_instr(issued_instr),
        .v_reg_wr_en(v_reg_wr_en), .x_reg_wr_en(x_reg_wr_en), .vconfig_wr_en(vconfig_wr_en),
        .busy(busy), .timeout_err(timeout_err)
    );

    // {start_vlanes, start_vred, start_vsldu, v_reg, x_reg, vconfig, busy, instr_ready, timeout_err}
    function automatic logic [8:0] outs();
        return {start_vlanes, start_vred, start_vsldu, v_reg_wr_en, x_reg_wr_en,
                vconfig_wr_en, busy, instr_ready, timeout_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0;
        instr       = '0;
        unit_sel    = '0;
        wb_dest     = '0;
        done_vlanes = 1'b0;
        done_vred   = 1'b0;
        done_vsldu  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++;
        if (outs() !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp %b", outs(), 9'b0);
        end
        checks++;
        if (issued_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_issued got %h exp %h", issued_instr, 32'h0);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (outs() !== 9'b000000010) begin
            errors++;
            $display("FAIL reset_release got %b exp %b", outs(), 9'b000000010);
        end
    endtask

    task automatic test_single_vlanes();
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            instr_valid = (c == 0);
            instr       = 32'h0220_8057;
            done_vlanes = (c == 5);
            if (c == 0) begin
                checks++;
                if (instr_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL single_ready c=%0d got %b exp 1", c, instr_ready);
                end
            end
            checks++;
            if (start_vlanes !== (c == 2)) begin
                errors++;
                $display("FAIL single_start c=%0d got %b exp %b", c, start_vlanes, (c == 2));
            end
            checks++;
            if (v_reg_wr_en !== (c == 6)) begin
                errors++;
                $display("FAIL single_vreg c=%0d got %b exp %b", c, v_reg_wr_en, (c == 6));
            end
            checks++;
            if (busy !== (c >= 1 && c <= 6)) begin
                errors++;
                $display("FAIL single_busy c=%0d got %b exp %b", c, busy, (c >= 1 && c <= 6));
            end
            checks++;
            if ({start_vred, start_vsldu, x_reg_wr_en, vconfig_wr_en} !== 4'b0) begin
                errors++;
                $display("FAIL single_others c=%0d got %b exp 0000", c,
                         {start_vred, start_vsldu, x_reg_wr_en, vconfig_wr_en});
            end
            if (c >= 2 && c <= 6) begin
                checks++;
                if (issued_instr !== 32'h0220_8057) begin
                    errors++;
                    $display("FAIL single_issued c=%0d got %h exp %h", c, issued_instr, 32'h0220_8057);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_config();
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            instr_valid = (c == 0);
            instr       = 32'h0C00_7057;
            unit_sel    = 2'd3;
            wb_dest     = 2'd3;
            checks++;
            if ({start_vlanes, start_vred, start_vsldu} !== 3'b0) begin
                errors++;
                $display("FAIL cfg_start c=%0d got %b exp 000", c, {start_vlanes, start_vred, start_vsldu});
            end
            checks++;
            if ({v_reg_wr_en, x_reg_wr_en, vconfig_wr_en} !== {2'b00, (c == 3)}) begin
                errors++;
                $display("FAIL cfg_wr c=%0d got %b exp %b", c,
                         {v_reg_wr_en, x_reg_wr_en, vconfig_wr_en}, {2'b00, (c == 3)});
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (issued_instr !== 32'h0C00_7057) begin
                    errors++;
                    $display("FAIL cfg_issued c=%0d got %h exp %h", c, issued_instr, 32'h0C00_7057);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_vred_ignore_other_done();
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            instr_valid = (c == 0);
            instr       = 32'h0E20_A057;
            unit_sel    = 2'd1;
            wb_dest     = 2'd1;
            done_vred   = (c == 2 || c == 6);
            done_vlanes = (c == 3);
            done_vsldu  = (c == 4);
            checks++;
            if (start_vred !== (c == 2)) begin
                errors++;
                $display("FAIL vred_start c=%0d got %b exp %b", c, start_vred, (c == 2));
            end
            checks++;
            if ({v_reg_wr_en, x_reg_wr_en, vconfig_wr_en} !== {1'b0, (c == 7), 1'b0}) begin
                errors++;
                $display("FAIL vred_wr c=%0d got %b exp %b", c,
                         {v_reg_wr_en, x_reg_wr_en, vconfig_wr_en}, {1'b0, (c == 7), 1'b0});
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_queue_full();
        logic [31:0] ia, ib, ic, id;
        logic        exp_ready;
        ia = 32'hA000_0001;
        ib = 32'hB000_0002;
        ic = 32'hC000_0003;
        id = 32'hD000_0004;
        for (int c = 0; c < 22; c++) begin
            idle_inputs();
            if (c == 0) begin
                instr_valid = 1'b1; instr = ia; unit_sel = 2'd2; wb_dest = 2'd1;
            end else if (c == 3) begin
                instr_valid = 1'b1; instr = ib; unit_sel = 2'd0; wb_dest = 2'd0;
            end else if (c == 4) begin
                instr_valid = 1'b1; instr = ic; unit_sel = 2'd1; wb_dest = 2'd1;
            end else if (c >= 5 && c <= 10) begin
                instr_valid = 1'b1; instr = id; unit_sel = 2'd3; wb_dest = 2'd2;
            end
            done_vsldu  = (c == 7);
            done_vlanes = (c == 11);
            done_vred   = (c == 15);
            exp_ready = !((c >= 5 && c <= 9) || (c >= 11 && c <= 13));
            checks++;
            if (instr_ready !== exp_ready) begin
                errors++;
                $display("FAIL qfull_ready c=%0d got %b exp %b", c, instr_ready, exp_ready);
            end
            checks++;
            if ({start_vlanes, start_vred, start_vsldu} !== {(c == 10), (c == 14), (c == 2)}) begin
                errors++;
                $display("FAIL qfull_start c=%0d got %b exp %b", c,
                         {start_vlanes, start_vred, start_vsldu}, {(c == 10), (c == 14), (c == 2)});
            end
            checks++;
            if ({v_reg_wr_en, x_reg_wr_en, vconfig_wr_en} !== {(c == 12), (c == 8 || c == 16), 1'b0}) begin
                errors++;
                $display("FAIL qfull_wr c=%0d got %b exp %b", c,
                         {v_reg_wr_en, x_reg_wr_en, vconfig_wr_en}, {(c == 12), (c == 8 || c == 16), 1'b0});
            end
            checks++;
            if (busy !== (c >= 1 && c <= 19)) begin
                errors++;
                $display("FAIL qfull_busy c=%0d got %b exp %b", c, busy, (c >= 1 && c <= 19));
            end
            if (c == 2 || c == 10 || c == 14 || c == 18) begin
                checks++;
                if (issued_instr !== (c == 2 ? ia : c == 10 ? ib : c == 14 ? ic : id)) begin
                    errors++;
                    $display("FAIL qfull_order c=%0d got %h exp %h", c, issued_instr,
                             (c == 2 ? ia : c == 10 ? ib : c == 14 ? ic : id));
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_wait();
        for (int c = 0; c < 13; c++) begin
            idle_inputs();
            instr_valid = (c == 0 || c == 1);
            instr       = (c == 0) ? 32'h1111_0001 : 32'h2222_0002;
            rst         = (c == 4 || c == 5);
            done_vlanes = (c == 7);
            #1;
            if (c == 2 || c == 3) begin
                checks++;
                if (outs() !== {(c == 2), 8'b0000_0110}) begin
                    errors++;
                    $display("FAIL rstwait_pre c=%0d got %b exp %b", c, outs(), {(c == 2), 8'b0000_0110});
                end
            end else if (c >= 4) begin
                checks++;
                if (outs() !== (c >= 6 ? 9'b000000010 : 9'b0)) begin
                    errors++;
                    $display("FAIL rstwait_outs c=%0d got %b exp %b", c, outs(),
                             (c >= 6 ? 9'b000000010 : 9'b0));
                end
                if (c == 4) begin
                    checks++;
                    if (issued_instr !== 32'h0) begin
                        errors++;
                        $display("FAIL rstwait_issued c=%0d got %h exp 0", c, issued_instr);
                    end
                end
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

`ifdef V_ISSUE_TIMEOUT_EN
    task automatic test_timeout_done_wins();
        for (int c = 0; c < 14; c++) begin
            idle_inputs();
            instr_valid = (c == 0);
            instr       = 32'h3333_0003;
            done_vlanes = (c == 10);
            checks++;
            if (v_reg_wr_en !== (c == 11)) begin
                errors++;
                $display("FAIL tmo_win_vreg c=%0d got %b exp %b", c, v_reg_wr_en, (c == 11));
            end
            checks++;
            if (timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL tmo_win_err c=%0d got %b exp 0", c, timeout_err);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        for (int c = 0; c < 17; c++) begin
            idle_inputs();
            instr_valid = (c == 0 || c == 1);
            instr       = (c == 0) ? 32'h4444_0004 : 32'h5555_0005;
            unit_sel    = (c == 0) ? 2'd0 : 2'd1;
            wb_dest     = (c == 0) ? 2'd0 : 2'd1;
            done_vred   = (c == 13);
            checks++;
            if (timeout_err !== (c >= 11)) begin
                errors++;
                $display("FAIL tmo_err c=%0d got %b exp %b", c, timeout_err, (c >= 11));
            end
            checks++;
            if ({start_vlanes, start_vred} !== {(c == 2), (c == 12)}) begin
                errors++;
                $display("FAIL tmo_start c=%0d got %b exp %b", c, {start_vlanes, start_vred},
                         {(c == 2), (c == 12)});
            end
            checks++;
            if ({v_reg_wr_en, x_reg_wr_en, vconfig_wr_en} !== {1'b0, (c == 14), 1'b0}) begin
                errors++;
                $display("FAIL tmo_wr c=%0d got %b exp %b", c,
                         {v_reg_wr_en, x_reg_wr_en, vconfig_wr_en}, {1'b0, (c == 14), 1'b0});
            end
            if (c == 12) begin
                checks++;
                if (issued_instr !== 32'h5555_0005) begin
                    errors++;
                    $display("FAIL tmo_next c=%0d got %h exp %h", c, issued_instr, 32'h5555_0005);
                end
            end
            tick();
        end
        idle_inputs();
    endtask
`else
    task automatic test_no_timeout();
        for (int c = 0; c < 104; c++) begin
            idle_inputs();
            instr_valid = (c == 0);
            instr       = 32'h6666_0006;
            done_vlanes = (c == 100);
            if (c == 12 || c == 70 || c == 99) begin
                checks++;
                if ({busy, timeout_err} !== 2'b10) begin
                    errors++;
                    $display("FAIL notmo_wait c=%0d got %b exp 10", c, {busy, timeout_err});
                end
            end
            checks++;
            if (v_reg_wr_en !== (c == 101)) begin
                errors++;
                $display("FAIL notmo_vreg c=%0d got %b exp %b", c, v_reg_wr_en, (c == 101));
            end
            tick();
        end
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_single_vlanes();
        test_config();
        test_vred_ignore_other_done();
        test_queue_full();
        test_reset_mid_wait();
`ifdef V_ISSUE_TIMEOUT_EN
        test_timeout_done_wins();
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
